// File: rtl/psx_poll_sequencer.sv
// psx_poll_sequencer: sequences one PSX controller poll frame per poll period.
// Drives ATT, hands command bytes to psx_byte_xfer via tx_start/tx_done, checks
// ACK after bytes 0..3, and publishes the ID and button bytes of good frames.
// All state advances on the falling edge of clk.
//
// Ports:
//   clk, rst_n   - clock (negedge active), async active-low reset
//   enable       - allows new frames to start
//   ack_n        - controller ACK, active-low, already synchronised
//   tx_done      - transceiver byte-finished pulse, rx_byte valid
//   rx_byte      - byte shifted in from the controller
//   att          - PSX attention, active-low
//   tx_start     - one-cycle send request, tx_byte held until tx_done
//   dev_id       - ID byte of last good frame
//   buttons      - {byte4, byte3} of last good frame, raw active-low
//   frame_valid  - pulse when dev_id/buttons update
//   frame_err    - pulse on abort, err_code: 01 ACK timeout, 10 bad marker
module psx_poll_sequencer #(
  parameter int unsigned POLL_PERIOD = 33333,
  parameter int unsigned ATT_SETUP   = 15,
  parameter int unsigned ACK_TIMEOUT = 200,
  parameter int unsigned BYTE_GAP    = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        ack_n,
  input  logic        tx_done,
  input  logic [7:0]  rx_byte,
  output logic        att,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic [7:0]  dev_id,
  output logic [15:0] buttons,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ATT_SETUP - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_MARKER  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ATT_LOW, S_SEND, S_WAIT_DONE, S_WAIT_ACK, S_GAP, S_FINISH, S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ack_seen_q, ack_seen_d;
  logic [1:0]        err_pend_q, err_pend_d;
  logic [7:0]        rx_id_q, rx_id_d, rx_mark_q, rx_mark_d;
  logic [7:0]        rx_lo_q, rx_lo_d, rx_hi_q, rx_hi_d;
  logic              att_d, tx_start_d, frame_valid_d, frame_err_d;
  logic [7:0]        tx_byte_d, dev_id_d;
  logic [15:0]       buttons_d;
  logic [1:0]        err_code_d;

  // Poll command: 01 42 00 00 00
  function automatic logic [7:0] cmd_byte(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0): return 8'h01;
      IDX_W'(1): return 8'h42;
      default:   return 8'h00;
    endcase
  endfunction

  // State and registered outputs
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      ack_seen_q  <= 1'b0;
      err_pend_q  <= 2'b00;
      rx_id_q     <= 8'h00;
      rx_mark_q   <= 8'h00;
      rx_lo_q     <= 8'hFF;
      rx_hi_q     <= 8'hFF;
      att         <= 1'b1;
      tx_start    <= 1'b0;
      tx_byte     <= 8'h00;
      dev_id      <= 8'h00;
      buttons     <= 16'hFFFF;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ack_seen_q  <= ack_seen_d;
      err_pend_q  <= err_pend_d;
      rx_id_q     <= rx_id_d;
      rx_mark_q   <= rx_mark_d;
      rx_lo_q     <= rx_lo_d;
      rx_hi_q     <= rx_hi_d;
      att         <= att_d;
      tx_start    <= tx_start_d;
      tx_byte     <= tx_byte_d;
      dev_id      <= dev_id_d;
      buttons     <= buttons_d;
      frame_valid <= frame_valid_d;
      frame_err   <= frame_err_d;
      err_code    <= err_code_d;
    end
  end

  // Next-state and output logic; a state's actions land on the edge that leaves it
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    ack_seen_d    = ack_seen_q;
    err_pend_d    = err_pend_q;
    rx_id_d       = rx_id_q;
    rx_mark_d     = rx_mark_q;
    rx_lo_d       = rx_lo_q;
    rx_hi_d       = rx_hi_q;
    att_d         = att;
    tx_start_d    = 1'b0;
    tx_byte_d     = tx_byte;
    dev_id_d      = dev_id;
    buttons_d     = buttons;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code;

    case (state_q)
      S_IDLE: begin
        // Counter saturates at POLL_LAST while enable is low
        if (cnt_q == POLL_LAST) begin
          if (enable) begin
            att_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_ATT_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ATT_LOW: begin
        if (cnt_q == SETUP_LAST) state_d = S_SEND;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end

      S_SEND: begin
        tx_start_d = 1'b1;
        tx_byte_d  = cmd_byte(idx_q);
        ack_seen_d = 1'b0;
        state_d    = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // ACK may arrive before or together with tx_done
        ack_seen_d = ack_seen_q | ~ack_n;
        if (tx_done) begin
          case (idx_q)
            IDX_W'(1): rx_id_d   = rx_byte;
            IDX_W'(2): rx_mark_d = rx_byte;
            IDX_W'(3): rx_lo_d   = rx_byte;
            IDX_W'(4): rx_hi_d   = rx_byte;
            default:   ;
          endcase
          cnt_d   = '0;
          state_d = (idx_q == IDX_W'(4)) ? S_FINISH : S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        // ACK takes priority over a coincident timeout
        if (ack_seen_q || !ack_n) begin
          if (idx_q == IDX_W'(2) && rx_mark_q != 8'h5A) begin
            err_pend_d = ERR_MARKER;
            state_d    = S_ABORT;
          end else begin
            cnt_d   = '0;
            state_d = S_GAP;
          end
        end else if (cnt_q == ACK_LAST) begin
          err_pend_d = ERR_TIMEOUT;
          state_d    = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FINISH: begin
        att_d         = 1'b1;
        dev_id_d      = rx_id_q;
        buttons_d     = {rx_hi_q, rx_lo_q};
        frame_valid_d = 1'b1;
        cnt_d         = '0;
        state_d       = S_IDLE;
      end

      S_ABORT: begin
        att_d       = 1'b1;
        frame_err_d = 1'b1;
        err_code_d  = err_pend_q;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_psx_poll_sequencer.sv
// Scoreboard bench for psx_poll_sequencer: the stimulus process plays the
// transceiver and controller, pushing expected command bytes and frame results;
// a monitor pops and compares on every tx_start and frame_valid/frame_err.
module tb_psx_poll_sequencer;

  localparam int unsigned P  = 40;
  localparam int unsigned S  = 5;
  localparam int unsigned AT = 12;
  localparam int unsigned B  = 4;
  localparam int unsigned XFER = 3;

  typedef struct packed {
    logic        valid;
    logic [7:0]  dev;
    logic [15:0] btn;
    logic [1:0]  code;
  } res_t;

  logic clk, rst_n, enable, ack_n, tx_done;
  logic [7:0] rx_byte;
  logic att, tx_start, frame_valid, frame_err;
  logic [7:0] tx_byte, dev_id;
  logic [15:0] buttons;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] exp_tx[$];
  res_t exp_res[$];
  logic [7:0] cmd_tab [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

  psx_poll_sequencer #(
    .POLL_PERIOD(P), .ATT_SETUP(S), .ACK_TIMEOUT(AT), .BYTE_GAP(B), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ack_n(ack_n), .tx_done(tx_done),
    .rx_byte(rx_byte), .att(att), .tx_start(tx_start), .tx_byte(tx_byte),
    .dev_id(dev_id), .buttons(buttons), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_code(err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents output
  initial begin : monitor
    logic att_prev;
    int fall_cyc;
    bit pend;
    logic [7:0] eb;
    res_t r;
    att_prev = 1'b1;
    fall_cyc = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      if (att_prev === 1'b1 && att === 1'b0) begin
        fall_cyc = cyc;
        pend = 1'b1;
      end
      att_prev = att;
      if (tx_start === 1'b1) begin
        if (pend) begin
          check("att_setup_cycles", 32'(cyc - fall_cyc), S + 1);
          pend = 1'b0;
        end
        if (exp_tx.size() == 0) flag("unexpected_tx_start");
        else begin
          eb = exp_tx.pop_front();
          check("tx_byte", {24'h0, tx_byte}, {24'h0, eb});
        end
      end
      if (frame_valid === 1'b1 || frame_err === 1'b1) begin
        if (exp_res.size() == 0) flag("unexpected_frame_pulse");
        else begin
          r = exp_res.pop_front();
          check("frame_kind", {30'h0, frame_valid, frame_err}, {30'h0, r.valid, ~r.valid});
          check("dev_id", {24'h0, dev_id}, {24'h0, r.dev});
          check("buttons", {16'h0, buttons}, {16'h0, r.btn});
          check("err_code", {30'h0, err_code}, {30'h0, r.code});
          check("att_high_at_frame_end", {31'h0, att}, 32'd1);
        end
      end
    end
  end

  task automatic push_frame(input int nbytes, input bit has_res, input res_t r);
    for (int i = 0; i < nbytes; i++) exp_tx.push_back(cmd_tab[i]);
    if (has_res) exp_res.push_back(r);
  endtask

  task automatic wait_att_fall(output int n);
    n = -1;
    for (int t = 1; t <= int'(4 * P); t++) begin
      @(posedge clk);
      if (att === 1'b0) begin
        n = t;
        break;
      end
    end
  endtask

  // Plays transceiver + controller for one frame
  task automatic run_frame(input logic [4:0][7:0] rep, input int ack_d, input int withhold_at,
                           input int nbytes, input int drop_at, input int reset_at,
                           output int fend, output int k_last);
    bit got;
    int k_prev;
    k_prev = 0;
    fend = 0;
    k_last = 0;
    for (int i = 0; i < nbytes; i++) begin
      got = 1'b0;
      for (int t = 0; t < int'(4 * P + 50); t++) begin
        @(posedge clk);
        if (tx_start === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        flag("tx_start_timeout");
        return;
      end
      if (i > 0 && ack_d == 0) check("gap_early_ack", 32'(cyc - k_prev), B + 3);
      if (i > 0 && ack_d == 3) check("gap_ack_d3", 32'(cyc - k_prev), B + 5);
      if (i == drop_at) enable = 1'b0;
      if (i == reset_at) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_att", {31'h0, att}, 32'd1);
        check("rst_tx_start", {31'h0, tx_start}, 32'd0);
        check("rst_buttons", {16'h0, buttons}, 32'hFFFF);
        check("rst_dev_id", {24'h0, dev_id}, 32'h00);
        check("rst_frame_err", {31'h0, frame_err}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      repeat (XFER) @(posedge clk);
      rx_byte = rep[i];
      tx_done = 1'b1;
      k_prev = cyc;
      k_last = cyc;
      if (ack_d == 0 && i < 4 && i != withhold_at) ack_n = 1'b0;
      @(posedge clk);
      tx_done = 1'b0;
      ack_n = 1'b1;
      if (ack_d > 0 && i < 4 && i != withhold_at) begin
        repeat (ack_d - 1) @(posedge clk);
        ack_n = 1'b0;
        @(posedge clk);
        ack_n = 1'b1;
      end
    end
    got = 1'b0;
    for (int t = 0; t < int'(4 * AT + 20); t++) begin
      @(posedge clk);
      if (frame_valid === 1'b1 || frame_err === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag("frame_end_timeout");
    fend = cyc;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int fend, k_last, n, lows;
    rst_n = 1'b1;
    enable = 1'b1;
    ack_n = 1'b1;
    tx_done = 1'b0;
    rx_byte = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    check("reset_att", {31'h0, att}, 32'd1);
    check("reset_tx_start", {31'h0, tx_start}, 32'd0);
    check("reset_tx_byte", {24'h0, tx_byte}, 32'h00);
    check("reset_dev_id", {24'h0, dev_id}, 32'h00);
    check("reset_buttons", {16'h0, buttons}, 32'hFFFF);
    check("reset_frame_valid", {31'h0, frame_valid}, 32'd0);
    check("reset_frame_err", {31'h0, frame_err}, 32'd0);
    check("reset_err_code", {30'h0, err_code}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_att_fall(n);
    check("first_att_fall", 32'(n), P);

    // A: ACK withheld after index 1
    push_frame(2, 1'b1, '{valid: 1'b0, dev: 8'h00, btn: 16'hFFFF, code: 2'b01});
    run_frame({8'h00, 8'h00, 8'h5A, 8'h23, 8'hFF}, 3, 1, 2, -1, -1, fend, k_last);
    check("timeout_latency", 32'(fend - k_last), AT + 2);
    wait_att_fall(n);
    check("poll_after_abort", 32'(n), P);

    // B: good digital frame
    push_frame(5, 1'b1, '{valid: 1'b1, dev: 8'h41, btn: 16'h7FFE, code: 2'b01});
    run_frame({8'h7F, 8'hFE, 8'h5A, 8'h41, 8'hFF}, 3, -1, 5, -1, -1, fend, k_last);
    check("finish_latency", 32'(fend - k_last), 32'd2);
    wait_att_fall(n);
    check("poll_after_good", 32'(n), P);

    // C: bad 0x5A marker
    push_frame(3, 1'b1, '{valid: 1'b0, dev: 8'h41, btn: 16'h7FFE, code: 2'b10});
    run_frame({8'h00, 8'h00, 8'h00, 8'h99, 8'hFF}, 3, -1, 3, -1, -1, fend, k_last);

    // D: ACK coincident with tx_done
    push_frame(5, 1'b1, '{valid: 1'b1, dev: 8'h73, btn: 16'hF00F, code: 2'b10});
    run_frame({8'hF0, 8'h0F, 8'h5A, 8'h73, 8'hFF}, 0, -1, 5, -1, -1, fend, k_last);

    // E: enable dropped during index 2
    push_frame(5, 1'b1, '{valid: 1'b1, dev: 8'h41, btn: 16'hCDAB, code: 2'b10});
    run_frame({8'hCD, 8'hAB, 8'h5A, 8'h41, 8'h00}, 3, -1, 5, 2, -1, fend, k_last);
    lows = 0;
    repeat (2 * P) begin
      @(posedge clk);
      if (att !== 1'b1) lows++;
    end
    check("att_idle_while_disabled", 32'(lows), 32'd0);
    enable = 1'b1;
    @(posedge clk);
    check("att_fall_after_enable", {31'h0, att}, 32'd0);

    // F: reset during index 3
    push_frame(4, 1'b0, '0);
    run_frame({8'h34, 8'h12, 8'h5A, 8'h41, 8'hFF}, 3, -1, 5, -1, 3, fend, k_last);
    wait_att_fall(n);
    check("poll_after_reset", 32'(n), P);

    // G: good frame after reset
    push_frame(5, 1'b1, '{valid: 1'b1, dev: 8'h41, btn: 16'h7FFE, code: 2'b00});
    run_frame({8'h7F, 8'hFE, 8'h5A, 8'h41, 8'hFF}, 3, -1, 5, -1, -1, fend, k_last);

    repeat (3) @(posedge clk);
    check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("exp_res_drained", 32'(exp_res.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
